keypad_scan_fifo: RTL

//  Parametrised successor to the fixed 4x4 keypad reader. Drives one-hot columns,

---
 rtl/keypad_scan_fifo.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: one-hot column scanner for a ROWS x COLS keypad.
// Rows are synchronised and debounced on both press and release. Each accepted
// press is pushed as row*COLS+col into a first-word-fall-through FIFO that has a
// valid/ready pop port and a registered head.
module keypad_scan_fifo #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 27000,
    parameter int DEBOUNCE = 4,
    parameter int DEPTH    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ROWS-1:0]                 filas_raw,
    output logic [COLS-1:0]                 columnas,
    output logic [$clog2(ROWS*COLS)-1:0]    key_code,
    output logic                            key_valid,
    input  logic                            key_ready,
    output logic [$clog2(DEPTH):0]          fifo_count,
    output logic                            key_held,
    output logic                            overflow
);

    localparam int CODE_W = $clog2(ROWS*COLS);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {S_SCAN, S_PRESS, S_HELD} state_t;

    logic [ROWS-1:0]   r_sync1;
    logic [ROWS-1:0]   r_sync2;
    logic [DIV_W-1:0]  r_div;
    state_t            r_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [DEB_W-1:0]  r_deb;
    logic              r_held;

    logic [CODE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [CODE_W-1:0] r_key_code;
    logic              r_overflow;

    logic              w_sample;
    logic              w_any;
    logic [ROW_W-1:0]  w_low_row;
    logic              w_row_bit;
    logic [COL_W-1:0]  w_col_inc;
    logic [ROW_W-1:0]  w_push_row;
    logic [CODE_W-1:0] w_code;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_wr;
    logic [PTR_W-1:0]  w_rptr_nxt;

    // Two-flop synchroniser on the raw row lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= filas_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running dwell counter; its terminal count is the sample cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_sample) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign w_sample = (r_div == DIV_W'(SCAN_DIV - 1));

    // Lowest-index active row wins when several rows are set at once
    always_comb begin
        w_any     = |r_sync2;
        w_low_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (r_sync2[i]) begin
                w_low_row = ROW_W'(i);
            end
        end
    end

    assign w_row_bit  = r_sync2[r_row];
    assign w_col_inc  = (r_col == COL_W'(COLS - 1)) ? '0 : r_col + COL_W'(1);
    // With a single-sample debounce the press is taken on the detection sample,
    // before r_row has been loaded, so the live row index is used then.
    assign w_push_row = (r_state == S_SCAN) ? w_low_row : r_row;
    assign w_code     = CODE_W'(32'(w_push_row) * 32'(COLS) + 32'(r_col));

    assign w_push = w_sample &&
                    (((r_state == S_SCAN) && w_any && (DEBOUNCE == 1)) ||
                     ((r_state == S_PRESS) && w_row_bit &&
                      (r_deb == DEB_W'(DEBOUNCE - 1))));

    // Scan / press-debounce / release-debounce state machine
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_SCAN;
            r_col   <= '0;
            r_row   <= '0;
            r_deb   <= '0;
            r_held  <= 1'b0;
        end else if (w_sample) begin
            case (r_state)
                S_SCAN: begin
                    if (w_any) begin
                        r_row <= w_low_row;
                        if (DEBOUNCE == 1) begin
                            r_state <= S_HELD;
                            r_deb   <= '0;
                            r_held  <= 1'b1;
                        end else begin
                            r_state <= S_PRESS;
                            r_deb   <= DEB_W'(1);
                        end
                    end else begin
                        r_col <= w_col_inc;
                    end
                end
                S_PRESS: begin
                    if (w_row_bit) begin
                        if (r_deb == DEB_W'(DEBOUNCE - 1)) begin
                            r_state <= S_HELD;
                            r_deb   <= '0;
                            r_held  <= 1'b1;
                        end else begin
                            r_deb <= r_deb + DEB_W'(1);
                        end
                    end else begin
                        r_state <= S_SCAN;
                        r_deb   <= '0;
                        r_col   <= w_col_inc;
                    end
                end
                S_HELD: begin
                    if (!w_row_bit) begin
                        if (r_deb == DEB_W'(DEBOUNCE - 1)) begin
                            r_state <= S_SCAN;
                            r_deb   <= '0;
                            r_held  <= 1'b0;
                            r_col   <= w_col_inc;
                        end else begin
                            r_deb <= r_deb + DEB_W'(1);
                        end
                    end else begin
                        r_deb <= '0;
                    end
                end
                default: begin
                    r_state <= S_SCAN;
                    r_deb   <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    // One-hot column drive decoded from the column index
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        assign columnas[gi] = (r_col == COL_W'(gi));
    end

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && key_ready;
    assign w_wr       = w_push && (!w_full || w_pop);
    assign w_rptr_nxt = r_rptr + PTR_W'(1);

    // FIFO storage; no reset so it maps onto distributed/block memory
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_code;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and the registered head
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_key_code <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            // Head follows the next entry; a lone entry being popped while a new
            // one is written hands the head straight to the incoming code.
            if (w_pop) begin
                if (r_count > CNT_W'(1)) begin
                    r_key_code <= r_mem[w_rptr_nxt];
                end else if (w_wr) begin
                    r_key_code <= w_code;
                end
            end else if (w_empty && w_wr) begin
                r_key_code <= w_code;
            end
        end
    end

    assign key_code   = r_key_code;
    assign key_valid  = !w_empty;
    assign fifo_count = r_count;
    assign key_held   = r_held;
    assign overflow   = r_overflow;

endmodule
